// File: rtl/tetris_gravity_timer.sv
// Gravity timer: counts 60 Hz frame ticks and raises a held "drop one row"
// request once the per-level interval elapses. A request stays up until
// acknowledged; a threshold reached while one is still pending only sets
// the sticky overrun flag.
module tetris_gravity_timer #(
  parameter int unsigned SOFT_FRAMES = 2,
  parameter int unsigned FRAME_W     = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic [3:0]         level,
  input  logic               soft_drop,
  input  logic               piece_spawn,
  input  logic               drop_ack,
  output logic               drop_req,
  output logic               drop_soft,
  output logic               overrun,
  output logic [FRAME_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {StIdle, StCount, StPending} state_e;

  state_e             state_q, state_d;
  logic               drop_req_q, drop_req_d;
  logic               drop_soft_q, drop_soft_d;
  logic               overrun_q, overrun_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  logic [FRAME_W-1:0] table_thr;
  logic [FRAME_W-1:0] soft_thr;
  logic [FRAME_W-1:0] threshold;
  logic [FRAME_W:0]   cnt_inc;
  logic               reached;

  // Frames-per-row lookup; soft drop can only shorten the interval.
  always_comb begin
    case (level)
      4'd0:    table_thr = FRAME_W'(48);
      4'd1:    table_thr = FRAME_W'(43);
      4'd2:    table_thr = FRAME_W'(38);
      4'd3:    table_thr = FRAME_W'(33);
      4'd4:    table_thr = FRAME_W'(28);
      4'd5:    table_thr = FRAME_W'(23);
      4'd6:    table_thr = FRAME_W'(18);
      4'd7:    table_thr = FRAME_W'(13);
      4'd8:    table_thr = FRAME_W'(8);
      4'd9:    table_thr = FRAME_W'(6);
      4'd10:   table_thr = FRAME_W'(5);
      4'd11:   table_thr = FRAME_W'(5);
      4'd12:   table_thr = FRAME_W'(5);
      4'd13:   table_thr = FRAME_W'(4);
      4'd14:   table_thr = FRAME_W'(4);
      default: table_thr = FRAME_W'(3);
    endcase
    soft_thr  = FRAME_W'(SOFT_FRAMES);
    threshold = (soft_drop && (soft_thr < table_thr)) ? soft_thr : table_thr;
  end

  // One extra bit so the increment compare cannot wrap; ">=" lets a lowered
  // threshold fire on the very next tick.
  assign cnt_inc = {1'b0, frame_cnt_q} + {{FRAME_W{1'b0}}, 1'b1};
  assign reached = (cnt_inc >= {1'b0, threshold});

  // Next-state logic, priority: disable > spawn > ack > tick.
  always_comb begin
    state_d     = state_q;
    drop_req_d  = drop_req_q;
    drop_soft_d = drop_soft_q;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;
    if (!enable) begin
      state_d     = StIdle;
      drop_req_d  = 1'b0;
      drop_soft_d = 1'b0;
      overrun_d   = 1'b0;
      frame_cnt_d = '0;
    end else if (piece_spawn) begin
      state_d     = StCount;
      drop_req_d  = 1'b0;
      drop_soft_d = 1'b0;
      overrun_d   = 1'b0;
      frame_cnt_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d     = StCount;
          frame_cnt_d = '0;
        end
        StCount: begin
          if (frame_tick) begin
            if (reached) begin
              state_d     = StPending;
              frame_cnt_d = '0;
              drop_req_d  = 1'b1;
              drop_soft_d = soft_drop;
            end else begin
              frame_cnt_d = cnt_inc[FRAME_W-1:0];
            end
          end
        end
        StPending: begin
          if (drop_ack) begin
            // Same-cycle tick is dropped; count is kept.
            state_d     = StCount;
            drop_req_d  = 1'b0;
            drop_soft_d = 1'b0;
          end else if (frame_tick) begin
            if (reached) begin
              overrun_d   = 1'b1;
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = cnt_inc[FRAME_W-1:0];
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      drop_req_q  <= 1'b0;
      drop_soft_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drop_req_q  <= drop_req_d;
      drop_soft_q <= drop_soft_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign drop_req  = drop_req_q;
  assign drop_soft = drop_soft_q;
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tetris_gravity_timer.sv
// Directed bench for tetris_gravity_timer. A second instance with
// SOFT_FRAMES=4 shares all inputs to cover soft-drop clamping.
module tb_tetris_gravity_timer;

  logic       clk = 1'b0;
  logic       reset, frame_tick, enable, soft_drop, piece_spawn, drop_ack;
  logic [3:0] level;
  logic       drop_req, drop_soft, overrun;
  logic [5:0] frame_cnt;
  logic       drop_req4, drop_soft4, overrun4;
  logic [5:0] frame_cnt4;

  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  tetris_gravity_timer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable), .level(level),
    .soft_drop(soft_drop), .piece_spawn(piece_spawn), .drop_ack(drop_ack),
    .drop_req(drop_req), .drop_soft(drop_soft), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  tetris_gravity_timer #(.SOFT_FRAMES(4), .FRAME_W(6)) dut4 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable), .level(level),
    .soft_drop(soft_drop), .piece_spawn(piece_spawn), .drop_ack(drop_ack),
    .drop_req(drop_req4), .drop_soft(drop_soft4), .overrun(overrun4), .frame_cnt(frame_cnt4)
  );

  // Inputs change 1 ns after a rising edge; outputs are read at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input int gap);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (gap) step();
  endtask

  task automatic do_ack();
    drop_ack = 1'b1;
    step();
    drop_ack = 1'b0;
  endtask

  task automatic do_spawn();
    piece_spawn = 1'b1;
    step();
    piece_spawn = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; frame_tick = 1'b0; soft_drop = 1'b0;
    piece_spawn = 1'b0; drop_ack = 1'b0; level = 4'd0;
    repeat (3) step();
    asserts++; if (drop_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", drop_req); end
    asserts++; if (drop_soft !== 1'b0) begin fails++; $display("FAIL reset_soft got %b exp 0", drop_soft); end
    asserts++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_ovr got %b exp 0", overrun); end
    asserts++; if (frame_cnt !== 6'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", frame_cnt); end
    reset = 1'b0; enable = 1'b1;
    step();
  endtask

  task automatic test_level0();
    level = 4'd0;
    for (int i = 0; i < 47; i++) do_tick(9);
    asserts++; if (frame_cnt !== 6'd47) begin fails++; $display("FAIL l0_cnt47 got %0d exp 47", frame_cnt); end
    asserts++; if (drop_req !== 1'b0) begin fails++; $display("FAIL l0_noreq got %b exp 0", drop_req); end
    do_tick(0);
    asserts++; if (drop_req !== 1'b1) begin fails++; $display("FAIL l0_req got %b exp 1", drop_req); end
    asserts++; if (drop_soft !== 1'b0) begin fails++; $display("FAIL l0_soft got %b exp 0", drop_soft); end
    asserts++; if (frame_cnt !== 6'd0) begin fails++; $display("FAIL l0_cnt0 got %0d exp 0", frame_cnt); end
    do_ack();
    asserts++; if (drop_req !== 1'b0) begin fails++; $display("FAIL l0_ack got %b exp 0", drop_req); end
  endtask

  task automatic test_level15();
    level = 4'd15;
    for (int r = 0; r < 3; r++) begin
      do_tick(1); do_tick(1);
      asserts++; if (drop_req !== 1'b0) begin fails++; $display("FAIL l15_early r%0d got %b exp 0", r, drop_req); end
      asserts++; if (frame_cnt !== 6'd2) begin fails++; $display("FAIL l15_cnt r%0d got %0d exp 2", r, frame_cnt); end
      do_tick(0);
      asserts++; if (drop_req !== 1'b1) begin fails++; $display("FAIL l15_req r%0d got %b exp 1", r, drop_req); end
      do_ack();
    end
    // Level change mid-interval: 20 frames counted at level 0, then level 9 (6 frames).
    level = 4'd0;
    for (int i = 0; i < 20; i++) do_tick(0);
    asserts++; if (frame_cnt !== 6'd20) begin fails++; $display("FAIL lvchg_cnt got %0d exp 20", frame_cnt); end
    level = 4'd9;
    do_tick(0);
    asserts++; if (drop_req !== 1'b1) begin fails++; $display("FAIL lvchg_req got %b exp 1", drop_req); end
    asserts++; if (frame_cnt !== 6'd0) begin fails++; $display("FAIL lvchg_cnt0 got %0d exp 0", frame_cnt); end
    do_ack();
  endtask

  task automatic test_soft_drop();
    level = 4'd0; soft_drop = 1'b1;
    for (int r = 0; r < 2; r++) begin
      do_tick(0);
      asserts++; if (drop_req !== 1'b0) begin fails++; $display("FAIL soft_early r%0d got %b exp 0", r, drop_req); end
      do_tick(0);
      asserts++; if (drop_req !== 1'b1) begin fails++; $display("FAIL soft_req r%0d got %b exp 1", r, drop_req); end
      asserts++; if (drop_soft !== 1'b1) begin fails++; $display("FAIL soft_flag r%0d got %b exp 1", r, drop_soft); end
      do_ack();
      asserts++; if (drop_soft !== 1'b0) begin fails++; $display("FAIL soft_clr r%0d got %b exp 0", r, drop_soft); end
    end
    // Level 15: SOFT_FRAMES=2 gives 2, SOFT_FRAMES=4 is clamped to table value 3.
    do_spawn();
    level = 4'd15;
    do_tick(0); do_tick(0);
    asserts++; if (drop_req !== 1'b1) begin fails++; $display("FAIL soft15_req got %b exp 1", drop_req); end
    asserts++; if (drop_req4 !== 1'b0) begin fails++; $display("FAIL soft15_req4_early got %b exp 0", drop_req4); end
    asserts++; if (frame_cnt4 !== 6'd2) begin fails++; $display("FAIL soft15_cnt4 got %0d exp 2", frame_cnt4); end
    do_tick(0);
    asserts++; if (drop_req4 !== 1'b1) begin fails++; $display("FAIL soft15_req4 got %b exp 1", drop_req4); end
    asserts++; if (drop_soft4 !== 1'b1) begin fails++; $display("FAIL soft15_soft4 got %b exp 1", drop_soft4); end
    asserts++; if (frame_cnt !== 6'd1) begin fails++; $display("FAIL soft15_pendcnt got %0d exp 1", frame_cnt); end
    soft_drop = 1'b0;
    do_spawn();
  endtask

  task automatic test_overrun();
    level = 4'd15;
    do_tick(0); do_tick(0); do_tick(0);
    asserts++; if (drop_req !== 1'b1) begin fails++; $display("FAIL ovr_req got %b exp 1", drop_req); end
    do_tick(0); do_tick(0);
    asserts++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_early got %b exp 0", overrun); end
    asserts++; if (frame_cnt !== 6'd2) begin fails++; $display("FAIL ovr_pendcnt got %0d exp 2", frame_cnt); end
    do_tick(0);
    asserts++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set got %b exp 1", overrun); end
    asserts++; if (drop_req !== 1'b1) begin fails++; $display("FAIL ovr_reqheld got %b exp 1", drop_req); end
    asserts++; if (frame_cnt !== 6'd0) begin fails++; $display("FAIL ovr_cnt got %0d exp 0", frame_cnt); end
    do_spawn();
    asserts++; if (overrun !== 1'b0) begin fails++; $display("FAIL spawn_ovr got %b exp 0", overrun); end
    asserts++; if (drop_req !== 1'b0) begin fails++; $display("FAIL spawn_req got %b exp 0", drop_req); end
    do_tick(0); do_tick(0); do_tick(0);
    asserts++; if (drop_req !== 1'b1) begin fails++; $display("FAIL spawn_count got %b exp 1", drop_req); end
  endtask

  task automatic test_back_to_back();
    // Pending from previous test with frame_cnt=0.
    do_tick(0);
    asserts++; if (frame_cnt !== 6'd1) begin fails++; $display("FAIL b2b_cnt1 got %0d exp 1", frame_cnt); end
    frame_tick = 1'b1; drop_ack = 1'b1;
    step();
    frame_tick = 1'b0; drop_ack = 1'b0;
    asserts++; if (drop_req !== 1'b0) begin fails++; $display("FAIL b2b_ackreq got %b exp 0", drop_req); end
    asserts++; if (frame_cnt !== 6'd1) begin fails++; $display("FAIL b2b_acktick got %0d exp 1", frame_cnt); end
    do_tick(0); do_tick(0);
    asserts++; if (drop_req !== 1'b1) begin fails++; $display("FAIL b2b_req got %b exp 1", drop_req); end
    do_tick(0);
    frame_tick = 1'b1; drop_ack = 1'b1; piece_spawn = 1'b1;
    step();
    frame_tick = 1'b0; drop_ack = 1'b0; piece_spawn = 1'b0;
    asserts++; if (frame_cnt !== 6'd0) begin fails++; $display("FAIL all3_cnt got %0d exp 0", frame_cnt); end
    asserts++; if (drop_req !== 1'b0) begin fails++; $display("FAIL all3_req got %b exp 0", drop_req); end
    // A stray ack outside PENDING does nothing.
    do_tick(0);
    do_ack();
    asserts++; if (frame_cnt !== 6'd1) begin fails++; $display("FAIL strayack_cnt got %0d exp 1", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    do_spawn();
    level = 4'd15;
    do_tick(0); do_tick(0); do_tick(0);
    asserts++; if (drop_req !== 1'b1) begin fails++; $display("FAIL rmid_pre got %b exp 1", drop_req); end
    reset = 1'b1;
    step();
    asserts++; if (drop_req !== 1'b0) begin fails++; $display("FAIL rmid_req got %b exp 0", drop_req); end
    drop_ack = 1'b1;
    step();
    reset = 1'b0;
    step();
    drop_ack = 1'b0;
    enable = 1'b0; step();
    enable = 1'b1; step();
    asserts++; if ({drop_req, drop_soft, overrun} !== 3'b000) begin
      fails++; $display("FAIL rmid_outs got %b exp 000", {drop_req, drop_soft, overrun});
    end
    asserts++; if (frame_cnt !== 6'd0) begin fails++; $display("FAIL rmid_cnt got %0d exp 0", frame_cnt); end
    level = 4'd0;
    for (int i = 0; i < 47; i++) do_tick(0);
    asserts++; if (drop_req !== 1'b0) begin fails++; $display("FAIL rmid_early got %b exp 0", drop_req); end
    do_tick(0);
    asserts++; if (drop_req !== 1'b1) begin fails++; $display("FAIL rmid_full got %b exp 1", drop_req); end
  endtask

  initial begin
    test_reset();
    test_level0();
    test_level15();
    test_soft_drop();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/tetris_gravity_timer.md
Name: tetris_gravity_timer

Overview:
- Consumes the single-cycle 60 Hz frame tick from the frame-rate divider.
- Issues gravity "drop one row" requests to the game-control FSM.
- Frames-per-row come from a per-level speed table; soft drop shortens the interval.
- Requests are held until acknowledged; never queued, never lost silently.

Parameters:
- SOFT_FRAMES, 2, frames per row while soft_drop is held (clamped to table value if smaller).
- FRAME_W, 6, width of frame counter; must hold the largest table entry (48).

Ports:
- clk  input  1  system clock (50 MHz).
- reset  input  1  synchronous, active-high reset.
- frame_tick  input  1  one-clk pulse per 1/60 s from the frame divider.
- enable  input  1  gravity active (game running, not paused).
- level  input  4  current level, 0..15.
- soft_drop  input  1  down key held.
- piece_spawn  input  1  one-clk pulse: new piece spawned, restart interval.
- drop_ack  input  1  game FSM has consumed the pending request.
- drop_req  output  1  level-held request to move piece down one row.
- drop_soft  output  1  request was generated under soft drop (scoring); valid while drop_req=1.
- overrun  output  1  sticky: a threshold was reached while a request was still pending.
- frame_cnt  output  FRAME_W  frames elapsed in current interval.

Behaviour:
- Reset: state IDLE; drop_req=0, drop_soft=0, overrun=0, frame_cnt=0.
- Speed table (frames/row, level 0..15): 48,43,38,33,28,23,18,13,8,6,5,5,5,4,4,3.
- threshold = soft_drop ? min(table[level], SOFT_FRAMES) : table[level]; evaluated combinationally in the cycle of each tick. Level/soft_drop changes take effect on the next tick.
- States: IDLE, COUNT, PENDING.
- Per-cycle priority: reset > enable=0 > piece_spawn > drop_ack > frame_tick.
- enable=0 (any state): go to IDLE and clear drop_req, drop_soft, overrun and frame_cnt.
- IDLE -> COUNT when enable=1; frame_cnt=0.
- COUNT, on frame_tick:
  - If frame_cnt+1 >= threshold: frame_cnt<=0, drop_req<=1, drop_soft<=soft_drop, go to PENDING. drop_req is visible the cycle after the tick (latency 1 clk).
  - Otherwise frame_cnt<=frame_cnt+1.
  - A threshold lowered below the current frame_cnt fires on the next tick; no underflow or wrap.
- PENDING:
  - drop_req held high until drop_ack.
  - Ticks keep counting into frame_cnt.
  - If a tick reaches threshold while pending: overrun<=1, frame_cnt<=0, no second request.
- drop_ack in PENDING: drop_req and drop_soft go to 0 the next cycle; state goes to COUNT; frame_cnt keeps its value.
  - A tick in the same cycle as drop_ack is ignored.
  - drop_ack outside PENDING has no effect.
- piece_spawn (enable=1): frame_cnt<=0, drop_req<=0, drop_soft<=0, overrun<=0, state COUNT. Wins over a same-cycle ack or tick.
- frame_cnt never exceeds 47; no wrap-around possible.
- reset mid-PENDING: all outputs 0 the next cycle; a subsequently asserted drop_ack is ignored.

Test Plan:
- Level 0, enable=1, 48 ticks spaced 10 clks -> drop_req=1 the clk after tick 48, drop_soft=0; frame_cnt=0; ack -> drop_req=0 next clk.
- Level 15 -> drop_req after every 3rd tick when acked promptly. Level changed 0->9 with frame_cnt=20 -> drop fires on the next tick.
- soft_drop=1 at level 0 -> request every 2 ticks with drop_soft=1. At level 15 with SOFT_FRAMES=4 -> threshold stays 3.
- Level 15 request left unacked for 3 further ticks -> overrun=1, drop_req stays 1, frame_cnt=0. piece_spawn -> overrun=0, drop_req=0, state COUNT.
- drop_ack and frame_tick in the same clk -> tick not counted (frame_cnt unchanged). piece_spawn+drop_ack+tick together -> frame_cnt=0, drop_req=0.
- reset asserted while drop_req=1, then enable=0/1 toggle -> all outputs 0. Counting restarts from 0 after reset deasserts; first drop arrives after the full table interval.
